// File: rtl/alice4_mem_pkg.sv
// Shared memory-side types for the alice4 SDRAM path.
// Widths, grant state and read-tag layout.
package alice4_mem_pkg;

  localparam int ADDR_W  = 29;
  localparam int DATA_W  = 64;
  localparam int BURST_W = 8;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_M0   = 2'd1,
    GNT_M1   = 2'd2
  } gnt_e;

  typedef enum logic {
    PORT_M0 = 1'b0,
    PORT_M1 = 1'b1
  } port_e;

  typedef struct packed {
    port_e               port;
    logic [BURST_W-1:0]  burst;
  } rd_tag_t;

endpackage

// File: rtl/read_tag_fifo.sv
// In-order FIFO of outstanding read tags {port, burstcount}.
// Head is the read whose data is currently returning.
module read_tag_fifo
  import alice4_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  rd_tag_t    din,
  input  logic       pop,
  output rd_tag_t    head,
  output logic       full,
  output logic       empty,
  output logic [4:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  rd_tag_t       mem [2**PW];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign head  = mem[rd_ptr];
  assign full  = (count == 5'(DEPTH));
  assign empty = (count == 5'd0);

  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= nxt(wr_ptr);
      if (pop)
        rd_ptr <= nxt(rd_ptr);
      unique case ({push, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-port SDRAM Avalon-MM arbiter: fixed priority m0, starvation-bounded m1.
// Define SDRAM_ARBITER_STATS_EN to build the debug_value* counters.
module sdram_arbiter
  import alice4_mem_pkg::*;
#(
  parameter int MAX_PENDING  = 4,
  parameter int STARVE_LIMIT = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  m0_address,
  input  logic [BURST_W-1:0] m0_burstcount,
  input  logic               m0_read,
  input  logic               m0_write,
  input  logic [DATA_W-1:0]  m0_writedata,
  input  logic [7:0]         m0_byteenable,
  output logic               m0_waitrequest,
  output logic [DATA_W-1:0]  m0_readdata,
  output logic               m0_readdatavalid,
  input  logic [ADDR_W-1:0]  m1_address,
  input  logic [BURST_W-1:0] m1_burstcount,
  input  logic               m1_read,
  input  logic               m1_write,
  input  logic [DATA_W-1:0]  m1_writedata,
  input  logic [7:0]         m1_byteenable,
  output logic               m1_waitrequest,
  output logic [DATA_W-1:0]  m1_readdata,
  output logic               m1_readdatavalid,
  output logic [ADDR_W-1:0]  s_address,
  output logic [BURST_W-1:0] s_burstcount,
  output logic               s_read,
  output logic               s_write,
  output logic [DATA_W-1:0]  s_writedata,
  output logic [7:0]         s_byteenable,
  input  logic               s_waitrequest,
  input  logic [DATA_W-1:0]  s_readdata,
  input  logic               s_readdatavalid,
  output logic [31:0]        debug_value0,
  output logic [31:0]        debug_value1,
  output logic [31:0]        debug_value2
);

  gnt_e         grant;
  gnt_e         grant_nxt;
  logic [7:0]   starve;
  logic [7:0]   wr_left;
  logic [7:0]   ret_cnt;

  rd_tag_t      head;
  logic         full;
  logic         empty;
  logic [4:0]   pending;

  logic         rd_acc;
  logic         wr_acc;
  logic         wr_last;
  logic         cmd_done;
  logic         ret_valid;
  logic         ret_last;
  logic         pop;
  logic         rd_ok;
  logic         m0_elig;
  logic         m1_elig;
  logic         starve_ok;

  always_comb begin
    s_address    = m0_address;
    s_burstcount = m0_burstcount;
    s_writedata  = m0_writedata;
    s_byteenable = m0_byteenable;
    s_read       = 1'b0;
    s_write      = 1'b0;
    unique case (1'b1)
      grant == GNT_M0: begin
        s_read  = m0_read;
        s_write = m0_write;
      end
      grant == GNT_M1: begin
        s_address    = m1_address;
        s_burstcount = m1_burstcount;
        s_writedata  = m1_writedata;
        s_byteenable = m1_byteenable;
        s_read       = m1_read;
        s_write      = m1_write;
      end
      default: ;
    endcase
  end

  assign m0_waitrequest = !(grant == GNT_M0 && !s_waitrequest);
  assign m1_waitrequest = !(grant == GNT_M1 && !s_waitrequest);

  assign rd_acc  = s_read && !s_waitrequest;
  assign wr_acc  = s_write && !s_waitrequest;
  assign wr_last = (wr_left == 8'd0) ? (s_burstcount <= 8'd1)
                                     : (wr_left == 8'd1);
  assign cmd_done = rd_acc || (wr_acc && wr_last);

  assign ret_valid = s_readdatavalid && !empty;
  assign ret_last  = (ret_cnt + 8'd1) >= head.burst;
  assign pop       = ret_valid && ret_last;

  assign m0_readdatavalid = ret_valid && head.port == PORT_M0;
  assign m1_readdatavalid = ret_valid && head.port == PORT_M1;
  assign m0_readdata = m0_readdatavalid ? s_readdata : '0;
  assign m1_readdata = m1_readdatavalid ? s_readdata : '0;

  // Room is judged after this cycle's push/pop so a handoff never
  // puts a read on the bus that the tag FIFO cannot hold.
  assign rd_ok = (!full || pop) &&
                 !(rd_acc && !pop && pending == 5'(MAX_PENDING - 1));

  assign m0_elig   = m0_write || (m0_read && rd_ok);
  assign m1_elig   = m1_write || (m1_read && rd_ok);
  assign starve_ok = starve < 8'(STARVE_LIMIT);

  always_comb begin
    grant_nxt = grant;
    unique case (1'b1)
      grant == GNT_NONE: begin
        if (m0_elig && starve_ok)
          grant_nxt = GNT_M0;
        else if (m1_elig)
          grant_nxt = GNT_M1;
        else if (m0_elig)
          grant_nxt = GNT_M0;
      end
      cmd_done && grant == GNT_M0:
        grant_nxt = m1_elig ? GNT_M1 : GNT_NONE;
      cmd_done && grant == GNT_M1:
        grant_nxt = m0_elig ? GNT_M0 : GNT_NONE;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant   <= GNT_NONE;
      starve  <= '0;
      wr_left <= '0;
      ret_cnt <= '0;
    end else begin
      grant <= grant_nxt;
      if (grant_nxt == GNT_M1)
        starve <= '0;
      else if (m1_elig && grant != GNT_M1 && starve_ok)
        starve <= starve + 8'd1;
      if (wr_acc)
        wr_left <= (wr_left == 8'd0) ? s_burstcount - 8'd1
                                     : wr_left - 8'd1;
      if (ret_valid)
        ret_cnt <= pop ? 8'd0 : ret_cnt + 8'd1;
    end
  end

  read_tag_fifo #(
    .DEPTH (MAX_PENDING)
  ) u_tags (
    .clock (clock),
    .reset (reset),
    .push  (rd_acc),
    .din   ('{port: (grant == GNT_M1) ? PORT_M1 : PORT_M0,
              burst: s_burstcount}),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (pending)
  );

`ifdef SDRAM_ARBITER_STATS_EN
  logic [31:0] cmd_cnt0;
  logic [31:0] cmd_cnt1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmd_cnt0 <= '0;
      cmd_cnt1 <= '0;
    end else if (cmd_done) begin
      if (grant == GNT_M0)
        cmd_cnt0 <= cmd_cnt0 + 32'd1;
      else
        cmd_cnt1 <= cmd_cnt1 + 32'd1;
    end
  end

  assign debug_value0 = cmd_cnt0;
  assign debug_value1 = cmd_cnt1;
  assign debug_value2 = {8'b0, starve, 4'b0, pending[3:0],
                         6'b0, grant};
`else
  assign debug_value0 = '0;
  assign debug_value1 = '0;
  assign debug_value2 = '0;
`endif

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Shares the single 64-bit SDRAM Avalon-MM master port between two requesters: port 0 is the frame-buffer scanout reader and port 1 is the rasterizer/general read-write master. Port 0 has fixed priority, and a starvation counter guarantees that port 1 eventually gets access. The block tracks outstanding reads so that each `readdatavalid` beat is routed back to the master that issued it. It sits between the requesters and the HPS/SDRAM bridge.

## Interface
Parameters:
- `MAX_PENDING`, default 4: maximum outstanding read commands, 1–16.
- `STARVE_LIMIT`, default 16: number of cycles port 1 may be refused before it wins, 1–255.

Ports:
- `clock` in 1: sole clock.
- `reset` in 1: asynchronous, active-high.
- `m0_address` / `m1_address` in 29: 64-bit word address.
- `m0_burstcount` / `m1_burstcount` in 8: beats per command, 1–255.
- `m0_read`, `m0_write`, `m1_read`, `m1_write` in 1: command strobes; at most one per port at a time.
- `m0_writedata` / `m1_writedata` in 64; `m0_byteenable` / `m1_byteenable` in 8.
- `m0_waitrequest` / `m1_waitrequest` out 1: master holds its command while this is high.
- `m0_readdata` / `m1_readdata` out 64; `m0_readdatavalid` / `m1_readdatavalid` out 1.
- `s_address` out 29; `s_burstcount` out 8; `s_read`, `s_write` out 1; `s_writedata` out 64; `s_byteenable` out 8: downstream command.
- `s_waitrequest` in 1; `s_readdata` in 64; `s_readdatavalid` in 1.
- `debug_value0`, `debug_value1`, `debug_value2` out 32: statistics for the LCD debug overlay.

## Operation
- Grant register with states `GNT_NONE`, `GNT_M0`, `GNT_M1`. Downstream address, burstcount, writedata and byteenable are muxed from the granted port; port 0 is selected in `GNT_NONE`.
- `s_read` = granted port's read. `s_write` = granted port's write. Both are 0 in `GNT_NONE`.
- Eligibility:
  - A port is eligible when it asserts read or write.
  - A read is ineligible while `pending == MAX_PENDING`.
- Arbitration from `GNT_NONE`:
  - If port 0 is eligible and `starve < STARVE_LIMIT`, grant port 0.
  - Otherwise, if port 1 is eligible, grant port 1.
- Acceptance: a command is accepted in a cycle where it is on `s_*` with `s_waitrequest` low. `mX_waitrequest` is low only in the granted port's accept cycles; it is high otherwise, including in `GNT_NONE`.
- Read command: one accept ends the command. The arbiter pushes `{port, burstcount}` into the tag FIFO and increments `pending`.
- Write command: the grant is held until `burstcount` beats are accepted. The beat counter loads on the first beat.
- End of command: the grant moves to the other port if that port is eligible; otherwise it moves to `GNT_NONE`. This allows alternating back-to-back commands with no bubble.
- Read return: on `s_readdatavalid`, `s_readdata` is routed to the port at the tag FIFO head, with that port's valid pulsed. The head's remaining-beat count decrements. On the last beat the FIFO pops and `pending` decrements.
- A simultaneous push and pop leaves `pending` unchanged.
- `s_readdatavalid` with an empty tag FIFO is a protocol error: the data is dropped and no valid is asserted.
- `starve` counter (8 bits):
  - Increments each cycle port 1 is eligible and not granted.
  - Saturates at `STARVE_LIMIT`.
  - Clears when port 1 is granted.
- Reset:
  - State: grant `GNT_NONE`, `pending` 0, tag FIFO empty, `starve` 0, beat counter 0.
  - Outputs: both waitrequests 1, `s_read` and `s_write` 0, valids 0, readdata 0, debug values 0.
- Reset mid-burst or with reads outstanding discards all tracking. Read data arriving after reset is dropped as a protocol error.

## Timing
- A request arriving in cycle N with grant `GNT_NONE` appears on `s_*` in N+1. The earliest accept is N+1.
- Handoff at end of command is zero-cycle: the next command is on `s_*` in the cycle after the accept.
- Read data passes through combinationally (`s_readdata` to `mX_readdata`), so there are 0 cycles of added return latency.
- `pending` full blocks new reads only. Writes still proceed.

## Configuration
- With `SDRAM_ARBITER_STATS_EN` defined, the debug outputs carry free-running, wrapping 32-bit counters:
  - `debug_value0`: port 0 accepted commands.
  - `debug_value1`: port 1 accepted commands.
  - `debug_value2`: `{8'b0, starve, 4'b0, pending[3:0], 6'b0, grant[1:0]}`.
- Without the macro, the debug outputs are constant 0 and the counters are not built.

## Structure
- Shared package `alice4_mem_pkg` holds:
  - the grant-state enum;
  - address width 29, data width 64, burstcount width 8;
  - the port-id type.
- Sub-module `read_tag_fifo`:
  - depth `MAX_PENDING`;
  - entry is `{port id, burstcount}`;
  - exposes head, push, pop, full, empty and count.

## Test plan
- Port 0 issues a 1-beat read to 0x100 with `s_waitrequest` low:
  - `s_read` is high one cycle after the request with `s_address` = 0x100.
  - Return data 0xDEAD_BEEF produces `m0_readdatavalid` = 1 with that data; `m1_readdatavalid` stays 0.
- Both ports request reads continuously: grants alternate m0, m1, m0 with no idle cycle between accepts.
- Port 0 requests reads continuously, port 1 write is held off with `MAX_PENDING` = 1 and memory never returns data:
  - port 0 blocks after one accept;
  - port 1's write is accepted within 2 cycles.
- Port 1 issues a 4-beat write while port 0 requests:
  - the grant is held for all 4 beats, including under random `s_waitrequest`;
  - port 0 is granted next.
- Port 0 issues a 2-beat read, port 1 issues a 3-beat read, then 5 return beats arrive:
  - beats 1–2 go to m0 and beats 3–5 go to m1;
  - `pending` returns to 0.
- Reset is asserted during beat 2 of a 4-beat write:
  - all outputs return to their reset values immediately;
  - after release, a port 1 read is granted normally.
